kbd_frame_tx: RTL and testbench

Serial frame transmitter that feeds the keyboard-matrix emulator. It holds the authoritative 8×5 key-press matrix and the 5-bit joystick state, and keeps them up to date on the emulator. Changed rows are sent as 13-bit frames over a three-wire link (`sclk`, `sdata`, `scs`), with periodic full refresh. It sits between the scancode/keymap decoder (upstream, which issues key events) and the matrix emulator (downstream, which is driven by the serial lines).

---
 rtl/kbd_pkg.sv | 40 ++++
 rtl/kbd_ser_phy.sv | 107 ++++++++++
 rtl/kbd_frame_tx.sv | 117 +++++++++++
 tb/tb_kbd_frame_tx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared constants, FSM encoding and the round-robin helper for the
// keyboard-matrix frame transmitter.
package kbd_pkg;

    localparam int FRAME_BITS = 13;
    localparam int ID_W       = 3;
    localparam int DATA_W     = 10;
    localparam int NGROUPS    = 5;
    localparam int NKEYS      = (NGROUPS - 1) * DATA_W;

    localparam logic [ID_W-1:0] ID_JOY = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIT_H = 3'd1,
        ST_BIT_L = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } phy_state_e;

    // First dirty group at or after (last + 1) mod NGROUPS.
    function automatic logic [ID_W-1:0] rr_pick(input logic [ID_W-1:0]    last,
                                                input logic [NGROUPS-1:0] dirty);
        logic [ID_W-1:0] g;
        logic [ID_W-1:0] pick;
        logic            found;
        g     = last;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NGROUPS; k++) begin
            g = (g == ID_JOY) ? '0 : g + 1'b1;
            if (!found && dirty[g]) begin
                pick  = g;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/kbd_ser_phy.sv
// Three-wire serial PHY: clock divider, link FSM and 13-bit MSB-first shifter.
// Outputs are registered from the state, so they lag the FSM by one clock.
module kbd_ser_phy
    import kbd_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int GAP_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  busy,
    output logic                  sclk,
    output logic                  sdata,
    output logic                  scs
);

    localparam int              CNT_MAX  = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int              CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]   DIV_LOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   GAP_LOAD = CW'(GAP_CYC - 1);
    localparam logic [3:0]      LAST_BIT = 4'(FRAME_BITS - 1);

    phy_state_e            st;
    logic [CW-1:0]         cnt;
    logic [3:0]            bit_idx;
    logic [FRAME_BITS-1:0] shreg;
    logic                  cnt_done;

    assign cnt_done = (cnt == '0);
    // The last gap clock doubles as the idle slot, so back-to-back frames
    // keep scs high for exactly GAP_CYC clocks.
    assign busy = !((st == ST_IDLE) || ((st == ST_GAP) && cnt_done));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= ST_GAP;
            cnt     <= GAP_LOAD;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (st)
                ST_IDLE, ST_GAP: begin
                    if (start && !busy) begin
                        st      <= ST_BIT_H;
                        cnt     <= DIV_LOAD;
                        bit_idx <= '0;
                        shreg   <= frame;
                    end else if (st == ST_GAP) begin
                        if (cnt_done) st  <= ST_IDLE;
                        else          cnt <= cnt - 1'b1;
                    end
                end
                ST_BIT_H: begin
                    if (cnt_done) begin
                        st  <= ST_BIT_L;
                        cnt <= DIV_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_BIT_L: begin
                    if (cnt_done) begin
                        cnt <= DIV_LOAD;
                        if (bit_idx == LAST_BIT) begin
                            st <= ST_STOP;
                        end else begin
                            st      <= ST_BIT_H;
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_done) begin
                        st  <= ST_GAP;
                        cnt <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    st  <= ST_GAP;
                    cnt <= GAP_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scs   <= 1'b1;
            sclk  <= 1'b1;
            sdata <= 1'b0;
        end else begin
            scs   <= (st == ST_IDLE) || (st == ST_GAP);
            sclk  <= (st != ST_BIT_L);
            sdata <= shreg[FRAME_BITS-1];
        end
    end

endmodule

// File: rtl/kbd_frame_tx.sv
// Key-matrix / joystick state holder with dirty tracking, refresh timer and
// round-robin frame scheduling onto the serial PHY.
module kbd_frame_tx
    import kbd_pkg::*;
#(
    parameter int CLK_DIV     = 8,
    parameter int GAP_CYC     = 16,
    parameter int REFRESH_CYC = 1 << 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [2:0] key_row,
    input  logic [2:0] key_col,
    input  logic       key_down,
    input  logic       key_clr,
    input  logic [4:0] joy,
    output logic       sclk,
    output logic       sdata,
    output logic       scs
);

    localparam int            RW      = $clog2(REFRESH_CYC);
    localparam logic [RW-1:0] REF_TOP = RW'(REFRESH_CYC - 1);

    logic [NKEYS-1:0]      pressed;
    logic [NKEYS-1:0]      pressed_clr;
    logic [NKEYS-1:0]      pressed_nxt;
    logic [NGROUPS-1:0]    dirty;
    logic [NGROUPS-1:0]    set_mask;
    logic [NGROUPS-1:0]    clr_mask;
    logic [4:0]            joy_reg;
    logic [ID_W-1:0]       last;
    logic [ID_W-1:0]       pick;
    logic [RW-1:0]         ref_cnt;
    logic                  ref_hit;
    logic                  key_hit;
    logic                  key_chg;
    logic [5:0]            key_idx;
    logic                  start;
    logic                  busy;
    logic                  take;
    logic [DATA_W-1:0]     payload;
    logic [FRAME_BITS-1:0] frame;

    assign ref_hit = (ref_cnt == REF_TOP);
    assign key_hit = key_valid && (key_col < 3'd5);
    assign key_idx = ({3'b000, key_row} << 2) + {3'b000, key_row} + {3'b000, key_col};

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        pressed_clr = key_clr ? '0 : pressed;
        pressed_nxt = pressed_clr;
        key_chg     = 1'b0;
        set_mask    = '0;
        if (key_hit) begin
            key_chg              = (pressed_clr[key_idx] != key_down);
            pressed_nxt[key_idx] = key_down;
        end
        if (key_clr)         set_mask[3:0]         = 4'hf;
        if (key_chg)         set_mask[key_row[2:1]] = 1'b1;
        if (joy != joy_reg)  set_mask[ID_JOY]      = 1'b1;
        if (ref_hit)         set_mask              = '1;
    end

    assign pick     = rr_pick(last, dirty);
    assign start    = |dirty;
    assign take     = start && !busy;
    assign clr_mask = take ? (NGROUPS'(1) << pick) : '0;

    always_comb begin
        payload = {5'b00000, joy_reg};
        case (pick)
            3'd0:    payload = pressed[9:0];
            3'd1:    payload = pressed[19:10];
            3'd2:    payload = pressed[29:20];
            3'd3:    payload = pressed[39:30];
            default: payload = {5'b00000, joy_reg};
        endcase
    end

    assign frame = {pick, payload};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pressed <= '0;
            joy_reg <= '0;
            dirty   <= '1;
            last    <= ID_JOY;
            ref_cnt <= '0;
        end else begin
            pressed <= pressed_nxt;
            joy_reg <= joy;
            // Set is OR-ed in after the clear so a fresh update re-dirties
            // a group whose snapshot is being taken this very cycle.
            dirty   <= (dirty & ~clr_mask) | set_mask;
            if (take) last <= pick;
            ref_cnt <= ref_hit ? '0 : ref_cnt + 1'b1;
        end
    end

    kbd_ser_phy #(
        .CLK_DIV (CLK_DIV),
        .GAP_CYC (GAP_CYC)
    ) u_phy (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .frame (frame),
        .busy  (busy),
        .sclk  (sclk),
        .sdata (sdata),
        .scs   (scs)
    );

endmodule

// File: tb/tb_kbd_frame_tx.sv
// Directed bench for kbd_frame_tx: a three-wire receiver captures each frame
// (value, sclk falling edges, scs-low clocks) and directed steps check them.
module tb_kbd_frame_tx;

    localparam int CLK_DIV     = 2;
    localparam int GAP_CYC     = 4;
    localparam int REFRESH_CYC = 8192;
    localparam int LOW_CLKS    = 27 * CLK_DIV;
    localparam int FLIM        = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [2:0] key_row = '0;
    logic [2:0] key_col = '0;
    logic       key_down = 1'b0;
    logic       key_clr = 1'b0;
    logic [4:0] joy = '0;
    logic       sclk;
    logic       sdata;
    logic       scs;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    kbd_frame_tx #(
        .CLK_DIV     (CLK_DIV),
        .GAP_CYC     (GAP_CYC),
        .REFRESH_CYC (REFRESH_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_down  (key_down),
        .key_clr   (key_clr),
        .joy       (joy),
        .sclk      (sclk),
        .sdata     (sdata),
        .scs       (scs)
    );

    // Receiver model: shift on sclk fall while selected, latch on scs rise.
    logic [12:0] rx_sh = '0;
    int          rx_total = 0;
    int          bits_at_fall = 0;
    time         t_fall = 0;
    logic [12:0] rx_f [0:127];
    int          rx_b [0:127];
    int          rx_l [0:127];
    int          rx_wr = 0;
    int          rx_rd = 0;

    always @(negedge sclk) begin
        if (scs === 1'b0) begin
            rx_sh    = {rx_sh[11:0], sdata};
            rx_total = rx_total + 1;
        end
    end

    always @(negedge scs) begin
        t_fall       = $time;
        bits_at_fall = rx_total;
    end

    always @(posedge scs) begin
        if (rst === 1'b0) begin
            rx_f[rx_wr % 128] = rx_sh;
            rx_b[rx_wr % 128] = rx_total - bits_at_fall;
            rx_l[rx_wr % 128] = int'(($time - t_fall) / 10);
            rx_wr = rx_wr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [2:0] r, input logic [2:0] c, input logic d, input logic clr);
        key_row   = r;
        key_col   = c;
        key_down  = d;
        key_valid = 1'b1;
        key_clr   = clr;
        tick();
        key_valid = 1'b0;
        key_clr   = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [12:0] f, input int limit);
        int n;
        n = 0;
        while (rx_wr == rx_rd && n < limit) begin
            tick();
            n++;
        end
        check({tag, " arrived"}, 32'(rx_wr != rx_rd), 32'd1);
        if (rx_wr != rx_rd) begin
            check({tag, " F"},    32'(rx_f[rx_rd % 128]), 32'(f));
            check({tag, " bits"}, 32'(rx_b[rx_rd % 128]), 32'd13);
            check({tag, " low"},  32'(rx_l[rx_rd % 128]), 32'(LOW_CLKS));
            rx_rd++;
        end
    endtask

    task automatic expect_none(input string tag, input int cycles);
        tick(cycles);
        check(tag, 32'(rx_wr - rx_rd), 32'd0);
        rx_rd = rx_wr;
    endtask

    task automatic init_sequence(input string tag);
        expect_frame({tag, " g0"}, 13'h0000, FLIM);
        expect_frame({tag, " g1"}, 13'h0400, FLIM);
        expect_frame({tag, " g2"}, 13'h0800, FLIM);
        expect_frame({tag, " g3"}, 13'h0c00, FLIM);
        expect_frame({tag, " g4"}, 13'h1000, FLIM);
    endtask

    initial begin
        int n;
        int b0;

        rst = 1'b1;
        tick(3);
        check("reset scs",   32'(scs),   32'd1);
        check("reset sclk",  32'(sclk),  32'd1);
        check("reset sdata", 32'(sdata), 32'd0);
        rst = 1'b0;
        rx_rd = rx_wr;
        init_sequence("init");

        // Single key, including the two-edge start latency from idle.
        tick(10);
        key(3'd3, 3'd2, 1'b1, 1'b0);
        check("lat t+0 scs", 32'(scs), 32'd1);
        tick();
        check("lat t+1 scs", 32'(scs), 32'd1);
        tick();
        check("lat t+2 scs", 32'(scs), 32'd0);
        expect_frame("press r3c2", 13'h0480, FLIM);
        expect_none("single frame only", 200);
        key(3'd3, 3'd2, 1'b0, 1'b0);
        expect_frame("release r3c2", 13'h0400, FLIM);
        key(3'd3, 3'd2, 1'b0, 1'b0);
        expect_none("release unchanged", 200);

        joy = 5'b10001;
        expect_frame("joy", 13'h1011, FLIM);
        expect_none("joy steady", 300);

        // Update arriving while its group is on the wire.
        tick(10);
        key(3'd1, 3'd0, 1'b1, 1'b0);
        n = 0;
        while (scs !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check("inflight scs low", 32'(scs), 32'd0);
        tick(10);
        key(3'd0, 3'd0, 1'b1, 1'b0);
        expect_frame("inflight first",  13'h0020, FLIM);
        expect_frame("inflight second", 13'h0021, FLIM);
        key(3'd1, 3'd0, 1'b0, 1'b0);
        expect_frame("release r1c0", 13'h0001, FLIM);

        // Clear together with a key write in the same cycle.
        key(3'd2, 3'd1, 1'b1, 1'b0);
        expect_frame("press r2c1", 13'h0402, FLIM);
        key(3'd6, 3'd3, 1'b1, 1'b0);
        expect_frame("press r6c3", 13'h0c08, FLIM);
        key(3'd7, 3'd4, 1'b1, 1'b1);
        expect_frame("clr g0", 13'h0000, FLIM);
        expect_frame("clr g1", 13'h0400, FLIM);
        expect_frame("clr g2", 13'h0800, FLIM);
        expect_frame("clr g3", 13'h0e00, FLIM);
        expect_none("clr done", 200);

        joy = 5'b00000;
        expect_frame("joy zero", 13'h1000, FLIM);

        // Reset during BIT_L of bit 5.
        tick(10);
        key(3'd0, 3'd0, 1'b1, 1'b0);
        b0 = rx_total;
        n  = 0;
        while ((rx_total - b0) < 6 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("midframe bit count", 32'(rx_total - b0), 32'd6);
        check("midframe sclk low",  32'(sclk), 32'd0);
        rst = 1'b1;
        #1;
        check("async rst scs",  32'(scs),  32'd1);
        check("async rst sclk", 32'(sclk), 32'd1);
        tick(3);
        rst = 1'b0;
        rx_rd = rx_wr;
        init_sequence("reinit");

        tick(10);
        key(3'd4, 3'd6, 1'b1, 1'b0);
        key(3'd7, 3'd5, 1'b1, 1'b0);
        expect_none("invalid col", 200);

        // Steady inputs: the next frames come only from the refresh timer.
        expect_frame("refresh g0", 13'h0000, REFRESH_CYC + 1000);
        expect_frame("refresh g1", 13'h0400, FLIM);
        expect_frame("refresh g2", 13'h0800, FLIM);
        expect_frame("refresh g3", 13'h0c00, FLIM);
        expect_frame("refresh g4", 13'h1000, FLIM);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
